sat_core_ctrl_seq: RTL and testbench
====================================

Name: sat_core_ctrl_seq

Overview:
Parametrised successor to the per-bin core controller. It sequences imply / decide / analyze / backtrack for one bin solve and reports sat, unsat (backtrack leaves the bin) or timeout. Beyond the previous controller it adds a conflict budget, saturating conflict/decision statistics and explicit priority rules. It sits between the bin-level top controller and the state_list / clause_array datapath.

Parameters:
WIDTH_LVL, 16, width of bin numbers and levels
WIDTH_CNT, 16, width of statistics counters and conflict budget

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start_core_i  in  1  start solving current bin (ignored unless IDLE)
done_core_o  out  1  one-cycle pulse, solve finished
cur_bin_num_i  in  WIDTH_LVL  bin under solve
conflict_budget_i  in  WIDTH_CNT  max conflicts per solve, 0 = unlimited; sampled at start
apply_imply_o  out  1  level request to imply unit
done_imply_i  in  1  imply complete
conflict_i  in  1  valid with done_imply_i
all_c_is_sat_i  in  1  valid with done_imply_i
start_decision_o  out  1  level request to decision unit
done_decision_i  in  1  decision complete
apply_analyze_o  out  1  level request to conflict analysis
done_analyze_i  in  1  analysis complete
bkt_bin_num_i  in  WIDTH_LVL  target bin of backtrack, valid with done_analyze_i
apply_bkt_cur_bin_o  out  1  level request for in-bin backtrack
done_bkt_cur_bin_i  in  1  backtrack complete
sat_o  out  1  result: bin satisfied
unsat_o  out  1  result: backtrack leaves bin
timeout_o  out  1  result: conflict budget exhausted
num_conflicts_o  out  WIDTH_CNT  conflicts this solve
num_decisions_o  out  WIDTH_CNT  decisions this solve

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; counters 0; latched budget 0. Reset mid-solve aborts immediately, no done pulse.
- States: IDLE, IMPLY, DECIDE, ANALYZE, BKT, DONE (binary encoded).
- IDLE: on start_core_i -> IMPLY next cycle; clear sat/unsat/timeout and both counters; latch conflict_budget_i.
- Each request output (apply_imply_o, start_decision_o, apply_analyze_o, apply_bkt_cur_bin_o) is registered and equals 1 exactly while in its state. At most one is high in any cycle. A done input is honoured only in its own state; done inputs seen in other states are ignored.
- IMPLY + done_imply_i:
  - conflict_i=1 -> increment conflicts, then ANALYZE. Conflict wins over all_c_is_sat_i.
  - else all_c_is_sat_i=1 -> DONE with sat.
  - else -> DECIDE.
- DECIDE + done_decision_i -> increment decisions, then IMPLY.
- ANALYZE + done_analyze_i:
  - bkt_bin_num_i != cur_bin_num_i -> DONE with unsat.
  - else if budget != 0 and conflicts >= budget -> DONE with timeout.
  - else -> BKT.
  - Unsat takes priority over timeout.
- BKT + done_bkt_cur_bin_i -> IMPLY.
- DONE: done_core_o=1 for exactly that one cycle, then IDLE. Exactly one of sat_o/unsat_o/timeout_o is 1. It is set on the DONE entry edge and held until the next accepted start or reset.
- Counters saturate at 2^WIDTH_CNT-1 (no wrap). Both counters hold their values after the solve until the next start.
- Latency: start to apply_imply_o = 1 cycle. A done input to the next request = 1 cycle. Final done input to done_core_o = 1 cycle.
- start_core_i asserted in any non-IDLE state is ignored, including in DONE.
- cur_bin_num_i must be stable during a solve; it is not latched.

Optional Feature:
SAT_CTRL_STATS_EN
- Defined: num_conflicts_o and num_decisions_o are driven from the counters as above.
- Undefined: the decision counter is removed and both stats outputs are tied to 0. The conflict counter stays internal so budget and timeout behave identically.

Test Plan:
- Start, done_imply with conflict=0 and sat=1 -> apply_imply 1 cycle after start; done_core_o pulse one cycle after done_imply; sat_o=1, counters 0/0.
- Three imply/decide rounds then sat=1 -> num_decisions_o=3 (stats on), num_conflicts_o=0, sat_o=1.
- Conflict; analyze returns bkt_bin_num_i=2 with cur_bin_num_i=5 -> unsat_o=1, num_conflicts_o=1, apply_bkt_cur_bin_o never asserted.
- conflict_budget_i=2, every imply conflicts, bkt_bin equals cur_bin -> one BKT pass, then timeout_o=1 after the 2nd analyze, num_conflicts_o=2.
- done_imply with conflict=1 and all_c_is_sat=1 together -> ANALYZE entered, sat_o stays 0. start_core_i pulsed during DECIDE -> no effect.
- rst asserted mid-ANALYZE -> all outputs 0 asynchronously, no done pulse. Fresh start afterwards completes normally.

Source files
------------

// File: rtl/sat_core_ctrl_seq_if.sv
// rtl/sat_core_ctrl_seq_if.sv - handshake bundle between bin controller, core sequencer and datapath units
interface sat_core_ctrl_seq_if #(
  parameter int WIDTH_LVL = 16,
  parameter int WIDTH_CNT = 16
);
  logic                 start_core_i;
  logic                 done_core_o;
  logic [WIDTH_LVL-1:0] cur_bin_num_i;
  logic [WIDTH_CNT-1:0] conflict_budget_i;
  logic                 apply_imply_o;
  logic                 done_imply_i;
  logic                 conflict_i;
  logic                 all_c_is_sat_i;
  logic                 start_decision_o;
  logic                 done_decision_i;
  logic                 apply_analyze_o;
  logic                 done_analyze_i;
  logic [WIDTH_LVL-1:0] bkt_bin_num_i;
  logic                 apply_bkt_cur_bin_o;
  logic                 done_bkt_cur_bin_i;
  logic                 sat_o;
  logic                 unsat_o;
  logic                 timeout_o;
  logic [WIDTH_CNT-1:0] num_conflicts_o;
  logic [WIDTH_CNT-1:0] num_decisions_o;

  // Driver side: bin controller plus the imply/decision/analysis/backtrack units
  modport master (
    output start_core_i, cur_bin_num_i, conflict_budget_i,
    output done_imply_i, conflict_i, all_c_is_sat_i,
    output done_decision_i, done_analyze_i, bkt_bin_num_i, done_bkt_cur_bin_i,
    input  done_core_o, apply_imply_o, start_decision_o, apply_analyze_o,
    input  apply_bkt_cur_bin_o, sat_o, unsat_o, timeout_o,
    input  num_conflicts_o, num_decisions_o
  );

  // Core sequencer side
  modport slave (
    input  start_core_i, cur_bin_num_i, conflict_budget_i,
    input  done_imply_i, conflict_i, all_c_is_sat_i,
    input  done_decision_i, done_analyze_i, bkt_bin_num_i, done_bkt_cur_bin_i,
    output done_core_o, apply_imply_o, start_decision_o, apply_analyze_o,
    output apply_bkt_cur_bin_o, sat_o, unsat_o, timeout_o,
    output num_conflicts_o, num_decisions_o
  );
endinterface

// File: rtl/sat_core_ctrl_seq.sv
// rtl/sat_core_ctrl_seq.sv - per-bin imply/decide/analyze/backtrack sequencer; SAT_CTRL_STATS_EN exposes statistics
module sat_core_ctrl_seq #(
  parameter int WIDTH_LVL = 16,
  parameter int WIDTH_CNT = 16
) (
  input logic                clk,
  input logic                rst,
  sat_core_ctrl_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_IMPLY   = 3'd1,
    ST_DECIDE  = 3'd2,
    ST_ANALYZE = 3'd3,
    ST_BKT     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 sat_q, sat_d;
  logic                 unsat_q, unsat_d;
  logic                 timeout_q, timeout_d;
  logic [WIDTH_CNT-1:0] conf_q, conf_d;
  logic [WIDTH_CNT-1:0] budget_q, budget_d;
  logic                 imply_q, decide_q, analyze_q, bkt_q, done_q;
`ifdef SAT_CTRL_STATS_EN
  logic [WIDTH_CNT-1:0] dec_q, dec_d;
`endif

  function automatic logic [WIDTH_CNT-1:0] sat_inc(input logic [WIDTH_CNT-1:0] v);
    return (v == {WIDTH_CNT{1'b1}}) ? v : v + WIDTH_CNT'(1);
  endfunction

  // Next-state, result flags and counters; each done input is only looked at in its own state
  always_comb begin
    state_d   = state_q;
    sat_d     = sat_q;
    unsat_d   = unsat_q;
    timeout_d = timeout_q;
    conf_d    = conf_q;
    budget_d  = budget_q;
`ifdef SAT_CTRL_STATS_EN
    dec_d     = dec_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start_core_i) begin
          state_d   = ST_IMPLY;
          sat_d     = 1'b0;
          unsat_d   = 1'b0;
          timeout_d = 1'b0;
          conf_d    = '0;
          budget_d  = bus.conflict_budget_i;
`ifdef SAT_CTRL_STATS_EN
          dec_d     = '0;
`endif
        end
      end
      ST_IMPLY: begin
        if (bus.done_imply_i) begin
          // a conflict outranks a simultaneous all-satisfied report
          if (bus.conflict_i) begin
            conf_d  = sat_inc(conf_q);
            state_d = ST_ANALYZE;
          end else if (bus.all_c_is_sat_i) begin
            sat_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_DECIDE;
          end
        end
      end
      ST_DECIDE: begin
        if (bus.done_decision_i) begin
`ifdef SAT_CTRL_STATS_EN
          dec_d   = sat_inc(dec_q);
`endif
          state_d = ST_IMPLY;
        end
      end
      ST_ANALYZE: begin
        if (bus.done_analyze_i) begin
          // leaving the bin is reported as unsat even when the budget is also spent
          if (bus.bkt_bin_num_i != bus.cur_bin_num_i) begin
            unsat_d = 1'b1;
            state_d = ST_DONE;
          end else if ((budget_q != '0) && (conf_q >= budget_q)) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_BKT;
          end
        end
      end
      ST_BKT: begin
        if (bus.done_bkt_cur_bin_i) state_d = ST_IMPLY;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register; request strobes and done pulse are decoded from the next state so they track the state exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sat_q     <= 1'b0;
      unsat_q   <= 1'b0;
      timeout_q <= 1'b0;
      conf_q    <= '0;
      budget_q  <= '0;
      imply_q   <= 1'b0;
      decide_q  <= 1'b0;
      analyze_q <= 1'b0;
      bkt_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef SAT_CTRL_STATS_EN
      dec_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sat_q     <= sat_d;
      unsat_q   <= unsat_d;
      timeout_q <= timeout_d;
      conf_q    <= conf_d;
      budget_q  <= budget_d;
      imply_q   <= (state_d == ST_IMPLY);
      decide_q  <= (state_d == ST_DECIDE);
      analyze_q <= (state_d == ST_ANALYZE);
      bkt_q     <= (state_d == ST_BKT);
      done_q    <= (state_d == ST_DONE);
`ifdef SAT_CTRL_STATS_EN
      dec_q     <= dec_d;
`endif
    end
  end

  assign bus.apply_imply_o       = imply_q;
  assign bus.start_decision_o    = decide_q;
  assign bus.apply_analyze_o     = analyze_q;
  assign bus.apply_bkt_cur_bin_o = bkt_q;
  assign bus.done_core_o         = done_q;
  assign bus.sat_o               = sat_q;
  assign bus.unsat_o             = unsat_q;
  assign bus.timeout_o           = timeout_q;
`ifdef SAT_CTRL_STATS_EN
  assign bus.num_conflicts_o     = conf_q;
  assign bus.num_decisions_o     = dec_q;
`else
  assign bus.num_conflicts_o     = '0;
  assign bus.num_decisions_o     = '0;
`endif

endmodule

// File: tb/tb_sat_core_ctrl_seq.sv
// tb/tb_sat_core_ctrl_seq.sv - directed self-checking bench for sat_core_ctrl_seq
module tb_sat_core_ctrl_seq;

`ifdef SAT_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sat_core_ctrl_seq_if #(.WIDTH_LVL(16), .WIDTH_CNT(16)) bus ();

  sat_core_ctrl_seq #(.WIDTH_LVL(16), .WIDTH_CNT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk1({tag, "_done"},    bus.done_core_o, 1'b0);
    chk1({tag, "_imply"},   bus.apply_imply_o, 1'b0);
    chk1({tag, "_decide"},  bus.start_decision_o, 1'b0);
    chk1({tag, "_analyze"}, bus.apply_analyze_o, 1'b0);
    chk1({tag, "_bkt"},     bus.apply_bkt_cur_bin_o, 1'b0);
    chk1({tag, "_sat"},     bus.sat_o, 1'b0);
    chk1({tag, "_unsat"},   bus.unsat_o, 1'b0);
    chk1({tag, "_timeout"}, bus.timeout_o, 1'b0);
    chkn({tag, "_nconf"},   bus.num_conflicts_o, 16'd0);
    chkn({tag, "_ndec"},    bus.num_decisions_o, 16'd0);
  endtask

  task automatic start_solve();
    bus.start_core_i = 1'b1;
    tick();
    bus.start_core_i = 1'b0;
  endtask

  task automatic imply_done(input logic conflict, input logic all_sat);
    bus.done_imply_i   = 1'b1;
    bus.conflict_i     = conflict;
    bus.all_c_is_sat_i = all_sat;
    tick();
    bus.done_imply_i   = 1'b0;
    bus.conflict_i     = 1'b0;
    bus.all_c_is_sat_i = 1'b0;
  endtask

  task automatic analyze_done(input logic [15:0] bkt_bin);
    bus.done_analyze_i = 1'b1;
    bus.bkt_bin_num_i  = bkt_bin;
    tick();
    bus.done_analyze_i = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst                    = 1'b1;
    bus.start_core_i       = 1'b0;
    bus.cur_bin_num_i      = 16'd5;
    bus.conflict_budget_i  = 16'd0;
    bus.done_imply_i       = 1'b0;
    bus.conflict_i         = 1'b0;
    bus.all_c_is_sat_i     = 1'b0;
    bus.done_decision_i    = 1'b0;
    bus.done_analyze_i     = 1'b0;
    bus.bkt_bin_num_i      = 16'd0;
    bus.done_bkt_cur_bin_i = 1'b0;

    // reset state
    tick();
    tick();
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // immediate sat
    start_solve();
    chk1("t1_imply_req", bus.apply_imply_o, 1'b1);
    chk1("t1_no_decide", bus.start_decision_o, 1'b0);
    imply_done(1'b0, 1'b1);
    chk1("t1_done", bus.done_core_o, 1'b1);
    chk1("t1_sat", bus.sat_o, 1'b1);
    chk1("t1_unsat", bus.unsat_o, 1'b0);
    chk1("t1_imply_drop", bus.apply_imply_o, 1'b0);
    chkn("t1_nconf", bus.num_conflicts_o, 16'd0);
    chkn("t1_ndec", bus.num_decisions_o, 16'd0);
    tick();
    chk1("t1_done_pulse", bus.done_core_o, 1'b0);
    chk1("t1_sat_hold", bus.sat_o, 1'b1);

    // three decide rounds, stray done and start pulses ignored
    start_solve();
    chk1("t2_sat_clr", bus.sat_o, 1'b0);
    bus.done_decision_i = 1'b1;
    tick();
    bus.done_decision_i = 1'b0;
    chk1("t2_stray_done_imply", bus.apply_imply_o, 1'b1);
    chk1("t2_stray_done_decide", bus.start_decision_o, 1'b0);
    for (int r = 0; r < 3; r++) begin
      imply_done(1'b0, 1'b0);
      chk1("t2_decide_req", bus.start_decision_o, 1'b1);
      chk1("t2_imply_off", bus.apply_imply_o, 1'b0);
      if (r == 1) begin
        bus.start_core_i = 1'b1;
        tick();
        bus.start_core_i = 1'b0;
        chk1("t2_start_ign_decide", bus.start_decision_o, 1'b1);
        chk1("t2_start_ign_imply", bus.apply_imply_o, 1'b0);
      end
      bus.done_decision_i = 1'b1;
      tick();
      bus.done_decision_i = 1'b0;
      chk1("t2_imply_again", bus.apply_imply_o, 1'b1);
    end
    imply_done(1'b0, 1'b1);
    chk1("t2_done", bus.done_core_o, 1'b1);
    chk1("t2_sat", bus.sat_o, 1'b1);
    chkn("t2_ndec", bus.num_decisions_o, STATS ? 16'd3 : 16'd0);
    chkn("t2_nconf", bus.num_conflicts_o, 16'd0);
    tick();
    chkn("t2_ndec_hold", bus.num_decisions_o, STATS ? 16'd3 : 16'd0);

    // backtrack leaves the bin -> unsat
    start_solve();
    chkn("t3_ndec_clr", bus.num_decisions_o, 16'd0);
    imply_done(1'b1, 1'b0);
    chk1("t3_analyze_req", bus.apply_analyze_o, 1'b1);
    chk1("t3_bkt_off_a", bus.apply_bkt_cur_bin_o, 1'b0);
    chkn("t3_nconf_a", bus.num_conflicts_o, STATS ? 16'd1 : 16'd0);
    analyze_done(16'd2);
    chk1("t3_done", bus.done_core_o, 1'b1);
    chk1("t3_unsat", bus.unsat_o, 1'b1);
    chk1("t3_sat", bus.sat_o, 1'b0);
    chk1("t3_timeout", bus.timeout_o, 1'b0);
    chk1("t3_bkt_off_d", bus.apply_bkt_cur_bin_o, 1'b0);
    chkn("t3_nconf", bus.num_conflicts_o, STATS ? 16'd1 : 16'd0);
    tick();

    // conflict budget of 2 -> one in-bin backtrack then timeout
    bus.conflict_budget_i = 16'd2;
    start_solve();
    bus.conflict_budget_i = 16'd0;
    chk1("t4_unsat_clr", bus.unsat_o, 1'b0);
    imply_done(1'b1, 1'b0);
    analyze_done(16'd5);
    chk1("t4_bkt_req", bus.apply_bkt_cur_bin_o, 1'b1);
    chk1("t4_analyze_off", bus.apply_analyze_o, 1'b0);
    chk1("t4_no_timeout_yet", bus.timeout_o, 1'b0);
    bus.done_bkt_cur_bin_i = 1'b1;
    tick();
    bus.done_bkt_cur_bin_i = 1'b0;
    chk1("t4_imply_req", bus.apply_imply_o, 1'b1);
    imply_done(1'b1, 1'b0);
    chkn("t4_nconf_a", bus.num_conflicts_o, STATS ? 16'd2 : 16'd0);
    analyze_done(16'd5);
    chk1("t4_done", bus.done_core_o, 1'b1);
    chk1("t4_timeout", bus.timeout_o, 1'b1);
    chk1("t4_unsat", bus.unsat_o, 1'b0);
    chk1("t4_sat", bus.sat_o, 1'b0);
    chk1("t4_bkt_off", bus.apply_bkt_cur_bin_o, 1'b0);
    chkn("t4_nconf", bus.num_conflicts_o, STATS ? 16'd2 : 16'd0);
    tick();
    chk1("t4_timeout_hold", bus.timeout_o, 1'b1);

    // conflict wins over all-sat, then reset mid-analyze
    start_solve();
    chk1("t5_timeout_clr", bus.timeout_o, 1'b0);
    imply_done(1'b1, 1'b1);
    chk1("t5_analyze_req", bus.apply_analyze_o, 1'b1);
    chk1("t5_sat_stays0", bus.sat_o, 1'b0);
    chk1("t5_no_done", bus.done_core_o, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk1("t5_async_analyze", bus.apply_analyze_o, 1'b0);
    chkn("t5_async_nconf", bus.num_conflicts_o, 16'd0);
    bus.done_analyze_i = 1'b1;
    bus.bkt_bin_num_i  = 16'd2;
    tick();
    chk_idle_outputs("t5_rst");
    bus.done_analyze_i = 1'b0;
    rst = 1'b0;
    tick();
    chk1("t5_idle_done", bus.done_core_o, 1'b0);
    start_solve();
    chk1("t5_restart_imply", bus.apply_imply_o, 1'b1);
    imply_done(1'b0, 1'b1);
    chk1("t5_restart_done", bus.done_core_o, 1'b1);
    chk1("t5_restart_sat", bus.sat_o, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
